// File: rtl/mac_operand_serializer.sv
`timescale 1ns/1ps
// Parallel-to-serial operand transmitter for the bit-serial MAC datapath.
// Optional macro SER_PARITY_EN appends an even-parity bit to every frame.
module mac_operand_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             init0_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
    typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_ser_bit;
    logic             r_ser_valid;
    logic             r_ser_first;
    logic             r_ser_last;
    logic             r_busy;
`ifdef SER_PARITY_EN
    logic             r_parity;
`endif

    logic [WIDTH-1:0] w_shifted;
    logic             w_next_head;
    logic             w_load_head;
    logic [CW-1:0]    w_cnt_next;

    // The head bit is always at one end of the register; shifting moves the
    // next bit into that position, so the outputs can be registered one cycle ahead.
    assign w_shifted   = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
    assign w_next_head = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];
    assign w_load_head = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    assign w_cnt_next  = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge init0_n) begin
        if (!init0_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_ser_bit   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_first <= 1'b0;
            r_ser_last  <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SER_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_state     <= S_SHIFT;
                        r_shift     <= in_data;
                        r_cnt       <= '0;
                        r_in_ready  <= 1'b0;
                        r_ser_bit   <= w_load_head;
                        r_ser_valid <= 1'b1;
                        r_ser_first <= 1'b1;
                        r_ser_last  <= 1'b0;
                        r_busy      <= 1'b1;
`ifdef SER_PARITY_EN
                        r_parity    <= ^in_data;
`endif
                    end
                end

                S_SHIFT: begin
                    if (ser_ready) begin
                        r_ser_first <= 1'b0;
                        r_shift     <= w_shifted;
                        r_cnt       <= w_cnt_next;
                        if (r_cnt == LAST_IDX) begin
`ifdef SER_PARITY_EN
                            r_state    <= S_PARITY;
                            r_ser_bit  <= r_parity;
                            r_ser_last <= 1'b1;
`else
                            r_state     <= S_IDLE;
                            r_cnt       <= '0;
                            r_in_ready  <= 1'b1;
                            r_ser_bit   <= 1'b0;
                            r_ser_valid <= 1'b0;
                            r_ser_last  <= 1'b0;
                            r_busy      <= 1'b0;
`endif
                        end else begin
                            r_ser_bit <= w_next_head;
`ifdef SER_PARITY_EN
                            r_ser_last <= 1'b0;
`else
                            r_ser_last <= (w_cnt_next == LAST_IDX);
`endif
                        end
                    end
                end

`ifdef SER_PARITY_EN
                S_PARITY: begin
                    if (ser_ready) begin
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                        r_in_ready  <= 1'b1;
                        r_ser_bit   <= 1'b0;
                        r_ser_valid <= 1'b0;
                        r_ser_first <= 1'b0;
                        r_ser_last  <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
`endif

                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_in_ready  <= 1'b1;
                    r_ser_bit   <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_ser_first <= 1'b0;
                    r_ser_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign ser_bit   = r_ser_bit;
    assign ser_valid = r_ser_valid;
    assign ser_first = r_ser_first;
    assign ser_last  = r_ser_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mac_operand_serializer.sv
`timescale 1ns/1ps
// Bench for mac_operand_serializer: LSB-first and MSB-first instances share stimulus
// and are checked every cycle against a frame-position model (honours SER_PARITY_EN).
module tb_mac_operand_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int   FRAME = W + 1;
    localparam logic PEN   = 1'b1;
`else
    localparam int   FRAME = W;
    localparam logic PEN   = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         init0_n = 1'b0;
    logic [W-1:0] inData = '0;
    logic         inValid = 1'b0;
    logic         serReady = 1'b1;

    logic lsbInReady, lsbSerBit, lsbSerValid, lsbSerFirst, lsbSerLast, lsbBusy;
    logic msbInReady, msbSerBit, msbSerValid, msbSerFirst, msbSerLast, msbBusy;

    int checks = 0;
    int errors = 0;
    bit compareEn = 1'b0;

    always #5 clk = ~clk;

    mac_operand_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .init0_n(init0_n), .in_data(inData), .in_valid(inValid),
        .in_ready(lsbInReady), .ser_bit(lsbSerBit), .ser_valid(lsbSerValid),
        .ser_ready(serReady), .ser_first(lsbSerFirst), .ser_last(lsbSerLast),
        .busy(lsbBusy)
    );

    mac_operand_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .init0_n(init0_n), .in_data(inData), .in_valid(inValid),
        .in_ready(msbInReady), .ser_bit(msbSerBit), .ser_valid(msbSerValid),
        .ser_ready(serReady), .ser_first(msbSerFirst), .ser_last(msbSerLast),
        .busy(msbBusy)
    );

    // Reference model: pos is the index of the bit on the wire, -1 when idle.
    int           pos = -1;
    logic [W-1:0] word = '0;

    always @(posedge clk or negedge init0_n) begin
        if (!init0_n) begin
            pos = -1;
        end else if (pos < 0) begin
            if (inValid) begin
                word = inData;
                pos  = 0;
            end
        end else if (serReady) begin
            pos = pos + 1;
            if (pos == FRAME) pos = -1;
        end
    end

    function automatic logic modelBit(input bit msbFirst);
        if (pos >= W) return ^word;
        return msbFirst ? word[W-1-pos] : word[pos];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareDut(input string tag, input bit msbFirst,
                              input logic inReady, input logic serValid, input logic serBit,
                              input logic serFirst, input logic serLast, input logic isBusy);
        bit idle;
        idle = (pos < 0);
        checkOutput({tag, "_in_ready"}, 32'(inReady), 32'(idle));
        checkOutput({tag, "_ser_valid"}, 32'(serValid), 32'(!idle));
        checkOutput({tag, "_busy"}, 32'(isBusy), 32'(!idle));
        if (!init0_n) begin
            checkOutput({tag, "_reset_bit"}, 32'(serBit), 32'd0);
            checkOutput({tag, "_reset_first"}, 32'(serFirst), 32'd0);
            checkOutput({tag, "_reset_last"}, 32'(serLast), 32'd0);
        end else if (!idle) begin
            checkOutput({tag, "_ser_bit"}, 32'(serBit), 32'(modelBit(msbFirst)));
            checkOutput({tag, "_ser_first"}, 32'(serFirst), 32'(pos == 0));
            checkOutput({tag, "_ser_last"}, 32'(serLast), 32'(pos == FRAME - 1));
        end
    endtask

    always @(negedge clk) begin
        if (compareEn) begin
            compareDut("lsb", 1'b0, lsbInReady, lsbSerValid, lsbSerBit, lsbSerFirst, lsbSerLast, lsbBusy);
            compareDut("msb", 1'b1, msbInReady, msbSerValid, msbSerBit, msbSerFirst, msbSerLast, msbBusy);
        end
    end

    task automatic applyStimulus(input logic valid, input logic [W-1:0] data, input logic ready);
        @(posedge clk);
        #1;
        inValid  = valid;
        inData   = data;
        serReady = ready;
    endtask

    // Sends one word from IDLE and records the transferred bits by position.
    task automatic sendFrame(input logic [W-1:0] w, input int stallAt, input int stallLen,
                             input bit holdNext, input logic [W-1:0] nextWord,
                             output logic [8:0] lsbSeq, output logic [8:0] msbSeq,
                             output logic [8:0] firstMask, output logic [8:0] lastMask,
                             output logic stallBit);
        int n, stalled, cyc;
        bit xfer;
        lsbSeq = '0; msbSeq = '0; firstMask = '0; lastMask = '0; stallBit = 1'b0;
        applyStimulus(1'b1, w, 1'b1);
        @(posedge clk);
        #1;
        inValid = holdNext;
        inData  = holdNext ? nextWord : '0;
        n = 0; stalled = 0; cyc = 0;
        while (n < FRAME && cyc < 200) begin
            serReady = !(n == stallAt && stalled < stallLen);
            @(negedge clk);
            xfer = lsbSerValid && serReady;
            if (xfer) begin
                lsbSeq[n]    = lsbSerBit;
                msbSeq[n]    = msbSerBit;
                firstMask[n] = lsbSerFirst;
                lastMask[n]  = lsbSerLast;
            end else if (!serReady) begin
                if (stalled == 0) stallBit = lsbSerBit;
                else checkOutput("stall_hold", 32'(lsbSerBit), 32'(stallBit));
                stalled++;
            end
            @(posedge clk);
            #1;
            if (xfer) n++;
            cyc++;
        end
        serReady = 1'b1;
        if (cyc >= 200) checkOutput("frame_timeout", 32'(n), 32'(FRAME));
        @(negedge clk);
        checkOutput("in_ready_after_last", 32'(lsbInReady), 32'd1);
    endtask

    initial begin
        logic [8:0] lsbSeq, msbSeq, firstMask, lastMask;
        logic       stallBit;

        compareEn = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", 32'(lsbInReady), 32'd1);
        checkOutput("reset_ser_valid", 32'(lsbSerValid), 32'd0);
        checkOutput("reset_busy", 32'(lsbBusy), 32'd0);
        @(posedge clk);
        #3 init0_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        sendFrame(8'hA5, -1, 0, 1'b0, 8'h00, lsbSeq, msbSeq, firstMask, lastMask, stallBit);
        checkOutput("a5_lsb_seq", 32'(lsbSeq), 32'h0A5);
        checkOutput("a5_msb_seq", 32'(msbSeq), 32'h0A5);
        checkOutput("a5_first_mask", 32'(firstMask), 32'h001);
        checkOutput("a5_last_mask", 32'(lastMask), 32'(9'h001 << (FRAME - 1)));

        sendFrame(8'h01, -1, 0, 1'b0, 8'h00, lsbSeq, msbSeq, firstMask, lastMask, stallBit);
        checkOutput("01_lsb_seq", 32'(lsbSeq), 32'({PEN, 8'h01}));
        checkOutput("01_msb_seq", 32'(msbSeq), 32'({PEN, 8'h80}));

        sendFrame(8'h3C, 2, 4, 1'b0, 8'h00, lsbSeq, msbSeq, firstMask, lastMask, stallBit);
        checkOutput("3c_stall_bit", 32'(stallBit), 32'd1);
        checkOutput("3c_lsb_seq", 32'(lsbSeq), 32'h03C);
        checkOutput("3c_msb_seq", 32'(msbSeq), 32'h03C);

        sendFrame(8'h0F, -1, 0, 1'b1, 8'hFF, lsbSeq, msbSeq, firstMask, lastMask, stallBit);
        checkOutput("0f_lsb_seq", 32'(lsbSeq), 32'h00F);
        checkOutput("0f_msb_seq", 32'(msbSeq), 32'h0F0);
        @(posedge clk);
        #1 inValid = 1'b0;
        @(negedge clk);
        checkOutput("ff_accepted_valid", 32'(lsbSerValid), 32'd1);
        checkOutput("ff_accepted_bit", 32'(lsbSerBit), 32'd1);
        checkOutput("ff_accepted_first", 32'(lsbSerFirst), 32'd1);
        repeat (FRAME + 2) @(posedge clk);
        #1;

`ifdef SER_PARITY_EN
        sendFrame(8'h07, -1, 0, 1'b0, 8'h00, lsbSeq, msbSeq, firstMask, lastMask, stallBit);
        checkOutput("07_lsb_seq", 32'(lsbSeq), 32'h107);
        checkOutput("07_msb_seq", 32'(msbSeq), 32'h1E0);
        checkOutput("07_last_mask", 32'(lastMask), 32'h100);
        sendFrame(8'h03, -1, 0, 1'b0, 8'h00, lsbSeq, msbSeq, firstMask, lastMask, stallBit);
        checkOutput("03_lsb_seq", 32'(lsbSeq), 32'h003);
        checkOutput("03_msb_seq", 32'(msbSeq), 32'h0C0);
`endif

        // Drop a frame mid-flight at bit index 3 with an asynchronous reset pulse.
        applyStimulus(1'b1, 8'hC3, 1'b1);
        @(posedge clk);
        #1 inValid = 1'b0;
        repeat (3) @(posedge clk);
        #2 init0_n = 1'b0;
        #1;
        checkOutput("midreset_ser_valid", 32'(lsbSerValid), 32'd0);
        checkOutput("midreset_in_ready", 32'(lsbInReady), 32'd1);
        checkOutput("midreset_busy", 32'(msbBusy), 32'd0);
        #1 init0_n = 1'b1;
        @(negedge clk);
        checkOutput("postreset_ser_valid", 32'(lsbSerValid), 32'd0);
        checkOutput("postreset_in_ready", 32'(msbInReady), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0));
        end
        applyStimulus(1'b0, '0, 1'b1);
        repeat (3 * FRAME) @(posedge clk);
        @(negedge clk);
        checkOutput("drain_idle", 32'(lsbInReady & msbInReady), 32'd1);

        compareEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mac_operand_serializer.md
Name: mac_operand_serializer

Overview:
- Parallel-to-serial transmitter for the bit-serial multiplier-accumulator datapath.
- Accepts a WIDTH-bit operand word through a valid/ready handshake and emits it one bit per accepted cycle on a serial stream.
- The stream feeds the per-bit loadable storage cells on the accumulator side, which capture each bit with their load enable.
- The stream carries first/last framing so the receiver knows where each operand starts and ends.

Parameters:
- WIDTH, 8: operand width in bits; must be at least 2.
- MSB_FIRST, 0: 0 sends bit 0 first; 1 sends bit WIDTH-1 first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- init0_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  parallel operand.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  serializer can accept a word this cycle.
- ser_bit  output  1  current serial data bit.
- ser_valid  output  1  ser_bit is valid.
- ser_ready  input  1  receiver accepts ser_bit this cycle (this is the receiver's load enable).
- ser_first  output  1  ser_bit is the first bit of a word.
- ser_last  output  1  ser_bit is the final bit of a frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (init0_n low, asynchronous): state=IDLE, shift register=0, bit counter=0. Outputs during reset: in_ready=1, ser_valid=0, ser_bit=0, ser_first=0, ser_last=0, busy=0.
- Reset asserted mid-frame: the frame is dropped immediately; it is not resumed after reset.
- State machine, IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid&in_ready: load the shift register with in_data, set the counter to 0, go to SHIFT.
- State machine, SHIFT:
  - in_ready=0, ser_valid=1, busy=1.
  - ser_bit is the current head bit: the LSB of the shift register, or the MSB when MSB_FIRST=1.
- Transfer rule: a bit is transferred only on a cycle where ser_valid&ser_ready. On a transfer, shift by one and increment the counter.
- Stall: while ser_ready=0, ser_bit, ser_first, ser_last and the counter hold their values indefinitely.
- ser_first = (counter==0) in SHIFT. ser_last = (counter==WIDTH-1) in SHIFT.
- End of frame: a transfer with ser_last=1 returns the FSM to IDLE. in_ready is high on the following cycle; there are no back-to-back words without an IDLE cycle.
- Latency: the first bit is valid on the cycle after the word is accepted. An unstalled frame occupies WIDTH cycles plus 1 IDLE cycle.
- in_valid while in SHIFT is ignored; it has no effect on the shift register.
- Counter width is clog2(WIDTH+1) and the counter never wraps within a frame.
- All outputs are registered or decoded from registered state only; there are no combinational paths from in_* to ser_*.

Optional Feature:
- Macro: SER_PARITY_EN.
- When defined:
  - After the WIDTH data bits, one extra PARITY cycle sends the even parity of the word (XOR of all in_data bits), computed at load.
  - ser_last is asserted only on the parity bit, and the frame is WIDTH+1 transfers.
  - The data bit at counter==WIDTH-1 has ser_last=0.
  - The parity bit obeys the same stall rule.
- When undefined: no PARITY state and no parity logic; the frame is WIDTH transfers, as specified above.

Test Plan:
- Reset: hold init0_n=0 → in_ready=1, ser_valid=0, busy=0. Pulse init0_n low while in SHIFT at counter=3 → next sample shows IDLE and ser_valid=0.
- Basic LSB-first: WIDTH=8, load 0xA5, ser_ready=1 → ser_bit sequence 1,0,1,0,0,1,0,1 on consecutive cycles; ser_first on bit 0, ser_last on bit 7; in_ready=1 the cycle after bit 7.
- MSB_FIRST=1: load 0xA5 → sequence 1,0,1,0,0,1,0,1 (MSB first); load 0x01 → sequence 0,0,0,0,0,0,0,1 with ser_last on the 1.
- Backpressure: load 0x3C, drop ser_ready for 4 cycles at counter=2 → ser_bit stays 1 and the counter stays 2 throughout; the frame resumes and completes with 8 transfers total.
- Ignored input: assert in_valid with 0xFF during SHIFT of 0x0F → stream is still 1,1,1,1,0,0,0,0; the 0xFF word is accepted only after return to IDLE.
- SER_PARITY_EN defined: load 0x07 → 8 data bits then parity 1, ser_last on the 9th transfer only; load 0x03 → parity bit 0.
